hdlc_symbol_serializer: RTL and testbench

Parametrised next-generation line encoder for the HDLC controller output path.
- Accepts whole data words through a valid/ready handshake and serialises them LSB-first.
- Maps each bit to a SYM_W-wide line symbol; words stream back-to-back with no gap symbols.
- A passthrough mode forwards a raw symbol bus unchanged.
- Sits between the HDLC framer (bit-stuffed word stream) and the transceiver symbol interface.

---
 rtl/hdlc_enc_pkg.sv | 29 ++
 rtl/hdlc_symbol_serializer.sv | 142 ++++++++++++++
 tb/tb_hdlc_symbol_serializer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_enc_pkg.sv
// Shared types and defaults for the HDLC line symbol serializer.
// Holds the state encoding, default line symbols and the counter-width helper.
package hdlc_enc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PASS  = 2'd2
    } state_e;

    localparam logic [7:0] SYM0_DEF     = 8'h96;
    localparam logic [7:0] SYM1_DEF     = 8'h99;
    localparam logic [7:0] IDLE_SYM_DEF = 8'h00;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/hdlc_symbol_serializer.sv
// Serialises HDLC framer words LSB-first into fixed-width line symbols,
// or forwards a raw symbol bus unchanged while activity is low.
module hdlc_symbol_serializer
    import hdlc_enc_pkg::*;
#(
    parameter int               DATA_W   = 8,
    parameter int               SYM_W    = 8,
    parameter logic [SYM_W-1:0] SYM0     = SYM_W'(SYM0_DEF),
    parameter logic [SYM_W-1:0] SYM1     = SYM_W'(SYM1_DEF),
    parameter logic [SYM_W-1:0] IDLE_SYM = SYM_W'(IDLE_SYM_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              activity,
    input  logic [SYM_W-1:0]  data_bus_in,
    input  logic [DATA_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic [SYM_W-1:0]  dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              done,
    output logic              abort
);

    localparam int               CNT_W    = clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [SYM_W-1:0]   dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic               accept_s;

    function automatic logic [SYM_W-1:0] sym_of(input logic b);
        return b ? SYM1 : SYM0;
    endfunction

    // Ready is held low during reset so no word can be taken while the block is cleared.
    assign word_ready = !rst && activity &&
                        ((state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == CNT_FULL)));
    assign accept_s   = word_ready && word_valid;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        abort_d      = 1'b0;

        if (!activity) begin
            // A word already fully emitted counts as complete, so only a partial one aborts.
            state_d      = PASS;
            dout_d       = data_bus_in;
            dout_valid_d = 1'b1;
            busy_d       = 1'b0;
            cnt_d        = '0;
            shreg_d      = '0;
            if ((state_q == SHIFT) && (cnt_q != CNT_FULL)) begin
                abort_d = 1'b1;
            end else begin
                abort_d = 1'b0;
            end
        end else if (accept_s) begin
            state_d      = SHIFT;
            dout_d       = sym_of(word_in[0]);
            shreg_d      = word_in >> 1;
            cnt_d        = CNT_W'(1);
            dout_valid_d = 1'b1;
            busy_d       = 1'b1;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q != CNT_FULL) begin
                        dout_d  = sym_of(shreg_q[0]);
                        shreg_d = shreg_q >> 1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        state_d      = IDLE;
                        dout_d       = IDLE_SYM;
                        dout_valid_d = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        cnt_d        = '0;
                    end
                end
                IDLE, PASS: begin
                    state_d      = IDLE;
                    dout_d       = IDLE_SYM;
                    dout_valid_d = 1'b0;
                    busy_d       = 1'b0;
                end
                default: begin
                    state_d      = IDLE;
                    dout_d       = IDLE_SYM;
                    dout_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    cnt_d        = '0;
                    shreg_d      = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign abort      = abort_q;

endmodule

// File: tb/tb_hdlc_symbol_serializer.sv
// Directed self-checking bench for hdlc_symbol_serializer (default parameters).
module tb_hdlc_symbol_serializer;

    logic       clk;
    logic       rst;
    logic       activity;
    logic [7:0] data_bus_in;
    logic [7:0] word_in;
    logic       word_valid;
    logic       word_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;
    logic       done;
    logic       abort;

    int n_tests;
    int n_fail;

    hdlc_symbol_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .activity    (activity),
        .data_bus_in (data_bus_in),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .busy        (busy),
        .done        (done),
        .abort       (abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_sym(input string tag, input logic [7:0] exp);
        check({tag, "_dout"}, 32'(dout), 32'(exp));
        check({tag, "_valid"}, 32'(dout_valid), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    function automatic logic [7:0] sym(input logic b);
        return b ? 8'h99 : 8'h96;
    endfunction

    logic [7:0] w;

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        activity    = 1'b1;
        word_valid  = 1'b1;
        word_in     = 8'h5A;
        data_bus_in = 8'h00;

        // Reset held for 3 cycles with a word offered
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_dout", 32'(dout), 32'h0);
            check("rst_valid", 32'(dout_valid), 32'd0);
            check("rst_ready", 32'(word_ready), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end

        // Single word A5
        rst     = 1'b0;
        word_in = 8'hA5;
        w       = 8'hA5;
        #1;
        check("a5_ready", 32'(word_ready), 32'd1);
        @(negedge clk);
        word_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_sym("a5_sym", sym(w[i]));
            @(negedge clk);
        end
        check("a5_idle_dout", 32'(dout), 32'h0);
        check("a5_idle_valid", 32'(dout_valid), 32'd0);
        check("a5_done", 32'(done), 32'd1);
        check("a5_busy_off", 32'(busy), 32'd0);

        // Back-to-back 00 then FF with no gap
        word_in    = 8'h00;
        word_valid = 1'b1;
        #1;
        check("b2b_ready0", 32'(word_ready), 32'd1);
        @(negedge clk);
        check("b2b_done_cleared", 32'(done), 32'd0);
        word_in = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            check_sym("b2b_sym", (i < 8) ? 8'h96 : 8'h99);
            check("b2b_ready", 32'(word_ready), (i == 7 || i == 15) ? 32'd1 : 32'd0);
            if (i == 8) begin
                word_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_idle_valid", 32'(dout_valid), 32'd0);

        // Passthrough
        activity    = 1'b0;
        data_bus_in = 8'h3C;
        #1;
        check("pass_ready_now", 32'(word_ready), 32'd0);
        @(negedge clk);
        check("pass_dout", 32'(dout), 32'h3C);
        check("pass_valid", 32'(dout_valid), 32'd1);
        check("pass_ready", 32'(word_ready), 32'd0);
        check("pass_busy", 32'(busy), 32'd0);
        check("pass_no_done", 32'(done), 32'd0);
        data_bus_in = 8'h5A;
        @(negedge clk);
        check("pass_dout2", 32'(dout), 32'h5A);
        activity = 1'b1;
        @(negedge clk);
        check("ret_dout", 32'(dout), 32'h0);
        check("ret_valid", 32'(dout_valid), 32'd0);
        check("ret_ready", 32'(word_ready), 32'd1);

        // Abort after 3 bits of F0
        word_in    = 8'hF0;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_sym("f0_sym", 8'h96);
            if (i < 2) begin
                @(negedge clk);
            end
        end
        activity    = 1'b0;
        data_bus_in = 8'hA7;
        word_in     = 8'hFF;
        word_valid  = 1'b1;
        #1;
        check("abort_ready", 32'(word_ready), 32'd0);
        @(negedge clk);
        check("abort_pulse", 32'(abort), 32'd1);
        check("abort_dout", 32'(dout), 32'hA7);
        check("abort_valid", 32'(dout_valid), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_cleared", 32'(abort), 32'd0);
        activity   = 1'b1;
        word_valid = 1'b0;
        @(negedge clk);
        check("abort_ret_dout", 32'(dout), 32'h0);

        // Fresh word after abort starts at bit 0, then reset mid-word at cnt=5
        word_in    = 8'h03;
        w          = 8'h03;
        word_valid = 1'b1;
        #1;
        check("fresh_ready", 32'(word_ready), 32'd1);
        @(negedge clk);
        word_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_sym("fresh_sym", sym(w[i]));
            if (i < 4) begin
                @(negedge clk);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        check("mrst_dout", 32'(dout), 32'h0);
        check("mrst_valid", 32'(dout_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_abort", 32'(abort), 32'd0);
        rst        = 1'b0;
        word_in    = 8'h02;
        w          = 8'h02;
        word_valid = 1'b1;
        #1;
        check("post_rst_ready", 32'(word_ready), 32'd1);
        @(negedge clk);
        word_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_sym("post_rst_sym", sym(w[i]));
            @(negedge clk);
        end
        check("post_rst_done", 32'(done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
